// File: rtl/join_pkg.sv
// Shared types and helpers for the fork/join collector.
// Mode/state encodings plus the completion test used by the FSM.
package join_pkg;

  localparam int MAX_TASKS = 32;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DRAIN  = 2'd3
  } join_state_e;

  // True when the low n bits of mask are all set.
  function automatic logic all_done(
    input logic [MAX_TASKS-1:0] mask,
    input int                   n
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_TASKS; i++) begin
      if (i < n && !mask[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/join_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted request.
// Returns 0 when no request is set.
module join_prio_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] id_o
);

  always_comb begin
    id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = W'(i);
    end
  end

endmodule

// File: rtl/join_barrier.sv
// Join end of a task-dispatch protocol: launches N workers and
// releases the parent per the latched JOIN_ALL/ANY/NONE mode.
module join_barrier
  import join_pkg::*;
#(
  parameter  int N_TASKS = 2,
  parameter  int CNT_W   = 16,
  localparam int FW      = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [N_TASKS-1:0] task_done_i,
  output logic [N_TASKS-1:0] task_start_o,
  output logic               busy_o,
  output logic               release_o,
  output logic               all_retired_o,
  output logic [N_TASKS-1:0] done_mask_o,
  output logic [FW-1:0]      first_id_o,
  output logic [CNT_W-1:0]   release_cycles_o
);

  join_state_e        state_q;
  join_mode_e         mode_q;
  join_mode_e         mode_d;
  logic [N_TASKS-1:0] ts_q;
  logic               busy_q;
  logic               rel_q;
  logic               ar_q;
  logic [N_TASKS-1:0] mask_q;
  logic [N_TASKS-1:0] mask_d;
  logic [FW-1:0]      fid_q;
  logic [FW-1:0]      enc_id;
  logic [CNT_W-1:0]   rc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               first_hit;
  logic               full;

  join_prio_enc #(
    .N (N_TASKS),
    .W (FW)
  ) u_enc (
    .req_i (task_done_i),
    .id_o  (enc_id)
  );

  // Mode 3 is an unused encoding and falls back to JOIN_ALL.
  assign mode_d    = (mode_i == 2'd3) ? JOIN_ALL
                                      : join_mode_e'(mode_i);
  assign mask_d    = mask_q | task_done_i;
  assign first_hit = (mask_q == '0) && (task_done_i != '0);
  assign full      = all_done(MAX_TASKS'(mask_d), N_TASKS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= JOIN_ALL;
      ts_q    <= '0;
      busy_q  <= 1'b0;
      rel_q   <= 1'b0;
      ar_q    <= 1'b0;
      mask_q  <= '0;
      fid_q   <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ts_q  <= '0;
      rel_q <= 1'b0;
      ar_q  <= 1'b0;
      if (state_q != IDLE && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_d;
            mask_q  <= '0;
            fid_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            ts_q    <= '1;
            busy_q  <= 1'b1;
            rel_q   <= (mode_d == JOIN_NONE);
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= (mode_q == JOIN_NONE) ? DRAIN : WAIT;
        end
        WAIT: begin
          mask_q <= mask_d;
          if (first_hit) fid_q <= enc_id;
          if (mode_q == JOIN_ANY && first_hit) begin
            rel_q <= 1'b1;
            rc_q  <= cnt_q;
            if (full) begin
              ar_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= DRAIN;
            end
          end else if (mode_q != JOIN_ANY && full) begin
            rel_q   <= 1'b1;
            ar_q    <= 1'b1;
            rc_q    <= cnt_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          mask_q <= mask_d;
          if (first_hit) fid_q <= enc_id;
          if (full) begin
            ar_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign task_start_o     = ts_q;
  assign busy_o           = busy_q;
  assign release_o        = rel_q;
  assign all_retired_o    = ar_q;
  assign done_mask_o      = mask_q;
  assign first_id_o       = fid_q;
  assign release_cycles_o = rc_q;

endmodule

// File: tb/tb_join_barrier.sv
// Scoreboard bench for join_barrier: expected output pulses are
// queued with stimulus and matched when the DUT pulses.
module tb_join_barrier;

  typedef struct {
    int cyc;
    int ts;
    int rel;
    int ar;
    int rc;
    int fid;
    int mask;
    int busy;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a = 0, start_b = 0, start_c = 0;
  logic [1:0]  mode_a = 0, mode_b = 0, mode_c = 0;
  logic [1:0]  done_a = 0;
  logic [3:0]  done_b = 0;
  logic [0:0]  done_c = 0;
  logic [1:0]  ts_a, mask_a;
  logic [3:0]  ts_b, mask_b;
  logic [0:0]  ts_c, mask_c;
  logic        busy_a, rel_a, ar_a;
  logic        busy_b, rel_b, ar_b;
  logic        busy_c, rel_c, ar_c;
  logic [0:0]  fid_a, fid_c;
  logic [1:0]  fid_b;
  logic [15:0] rc_a, rc_b;
  logic [2:0]  rc_c;

  join_barrier #(.N_TASKS(2), .CNT_W(16)) u_a (
    .clk (clk), .rst_n (rst_n),
    .start_i (start_a), .mode_i (mode_a),
    .task_done_i (done_a), .task_start_o (ts_a),
    .busy_o (busy_a), .release_o (rel_a),
    .all_retired_o (ar_a), .done_mask_o (mask_a),
    .first_id_o (fid_a), .release_cycles_o (rc_a)
  );

  join_barrier #(.N_TASKS(4), .CNT_W(16)) u_b (
    .clk (clk), .rst_n (rst_n),
    .start_i (start_b), .mode_i (mode_b),
    .task_done_i (done_b), .task_start_o (ts_b),
    .busy_o (busy_b), .release_o (rel_b),
    .all_retired_o (ar_b), .done_mask_o (mask_b),
    .first_id_o (fid_b), .release_cycles_o (rc_b)
  );

  join_barrier #(.N_TASKS(1), .CNT_W(3)) u_c (
    .clk (clk), .rst_n (rst_n),
    .start_i (start_c), .mode_i (mode_c),
    .task_done_i (done_c), .task_start_o (ts_c),
    .busy_o (busy_c), .release_o (rel_c),
    .all_retired_o (ar_c), .done_mask_o (mask_c),
    .first_id_o (fid_c), .release_cycles_o (rc_c)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic mon_cmp(string p, ev_t e, int ts, int rel, int ar,
                         int rc, int fid, int mask, int busy);
    chk({p, "_cyc"}, cyc, e.cyc);
    chk({p, "_task_start"}, ts, e.ts);
    chk({p, "_release"}, rel, e.rel);
    chk({p, "_all_retired"}, ar, e.ar);
    chk({p, "_release_cycles"}, rc, e.rc);
    chk({p, "_first_id"}, fid, e.fid);
    chk({p, "_done_mask"}, mask, e.mask);
    chk({p, "_busy"}, busy, e.busy);
  endtask

  always @(negedge clk) begin
    if (ts_a != 0 || rel_a || ar_a) begin
      if (q_a.size() == 0) chk("a_unexpected", int'({ts_a, rel_a, ar_a}), 0);
      else mon_cmp("a", q_a.pop_front(), ts_a, rel_a, ar_a,
                   rc_a, fid_a, mask_a, busy_a);
    end
  end

  always @(negedge clk) begin
    if (ts_b != 0 || rel_b || ar_b) begin
      if (q_b.size() == 0) chk("b_unexpected", int'({ts_b, rel_b, ar_b}), 0);
      else mon_cmp("b", q_b.pop_front(), ts_b, rel_b, ar_b,
                   rc_b, fid_b, mask_b, busy_b);
    end
  end

  always @(negedge clk) begin
    if (ts_c != 0 || rel_c || ar_c) begin
      if (q_c.size() == 0) chk("c_unexpected", int'({ts_c, rel_c, ar_c}), 0);
      else mon_cmp("c", q_c.pop_front(), ts_c, rel_c, ar_c,
                   rc_c, fid_c, mask_c, busy_c);
    end
  end

  task automatic push(int s, ev_t e);
    case (s)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic set_start(int s, logic st, logic [1:0] md);
    case (s)
      0:       begin start_a = st; mode_a = md; end
      1:       begin start_b = st; mode_b = md; end
      default: begin start_c = st; mode_c = md; end
    endcase
  endtask

  task automatic set_done(int s, logic [3:0] dn);
    case (s)
      0:       done_a = dn[1:0];
      1:       done_b = dn;
      default: done_c = dn[0:0];
    endcase
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(int s, logic [1:0] md, bit keep, output int c0);
    int ones;
    ones = (s == 0) ? 3 : (s == 1) ? 15 : 1;
    set_start(s, 1'b1, md);
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!keep) set_start(s, 1'b0, md);
    push(s, '{c0, ones, (md == 2) ? 1 : 0, 0, 0, 0, 0, 1});
  endtask

  task automatic pulse(int s, logic [3:0] dn, int t);
    wait_to(t);
    set_done(s, dn);
    @(posedge clk);
    #1;
    set_done(s, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    int c1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_task_start", ts_a, 0);
    chk("rst_release", rel_a, 0);
    chk("rst_all_retired", ar_a, 0);
    chk("rst_done_mask", mask_a, 0);
    chk("rst_first_id", fid_a, 0);
    chk("rst_release_cycles", rc_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    set_done(0, 4'd3);
    idle(1);
    set_done(0, 4'd0);
    idle(1);
    chk("idle_done_mask", mask_a, 0);
    chk("idle_busy", busy_a, 0);

    // JOIN_ALL, with a stray start during WAIT
    launch(0, 2'd0, 0, c0);
    wait_to(c0 + 10);
    set_start(0, 1'b1, 2'd0);
    idle(1);
    set_start(0, 1'b0, 2'd0);
    pulse(0, 4'd1, c0 + 20);
    push(0, '{c0 + 31, 0, 1, 1, 30, 0, 3, 0});
    pulse(0, 4'd2, c0 + 30);
    idle(3);
    chk("all_done_mask", mask_a, 3);
    chk("all_release_cycles", rc_a, 30);

    // JOIN_ANY
    launch(0, 2'd1, 0, c0);
    push(0, '{c0 + 21, 0, 1, 0, 20, 0, 1, 1});
    pulse(0, 4'd1, c0 + 20);
    idle(4);
    chk("any_busy_held", busy_a, 1);
    push(0, '{c0 + 31, 0, 0, 1, 20, 0, 3, 0});
    pulse(0, 4'd2, c0 + 30);
    idle(3);

    // JOIN_NONE
    launch(0, 2'd2, 0, c0);
    pulse(0, 4'd1, c0 + 20);
    push(0, '{c0 + 31, 0, 0, 1, 0, 0, 3, 0});
    pulse(0, 4'd2, c0 + 30);
    idle(5);

    // JOIN_ANY, N=4: simultaneous, duplicate, last
    launch(1, 2'd1, 0, c0);
    push(1, '{c0 + 6, 0, 1, 0, 5, 2, 12, 1});
    pulse(1, 4'b1100, c0 + 5);
    pulse(1, 4'b0101, c0 + 8);
    push(1, '{c0 + 13, 0, 0, 1, 5, 2, 15, 0});
    pulse(1, 4'b0010, c0 + 12);
    idle(3);
    chk("n4_done_mask", mask_b, 15);

    // start held high: back-to-back forks
    launch(0, 2'd0, 1, c0);
    push(0, '{c0 + 6, 0, 1, 1, 5, 0, 3, 0});
    push(0, '{c0 + 7, 3, 0, 0, 0, 0, 0, 1});
    pulse(0, 4'd3, c0 + 5);
    idle(1);
    set_start(0, 1'b0, 2'd0);
    c1 = c0 + 7;
    push(0, '{c1 + 4, 0, 1, 1, 3, 0, 3, 0});
    pulse(0, 4'd3, c1 + 3);
    idle(3);

    // reset in WAIT after done[0]
    launch(0, 2'd0, 0, c0);
    pulse(0, 4'd1, c0 + 5);
    wait_to(c0 + 8);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", busy_a, 0);
    chk("rr_done_mask", mask_a, 0);
    chk("rr_release", rel_a, 0);
    chk("rr_all_retired", ar_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(30);
    launch(0, 2'd0, 0, c0);
    push(0, '{c0 + 3, 0, 1, 1, 2, 0, 3, 0});
    pulse(0, 4'd3, c0 + 2);
    idle(3);

    // N=1 JOIN_ANY with a 3-bit saturating counter
    launch(2, 2'd1, 0, c0);
    push(2, '{c0 + 13, 0, 1, 1, 7, 0, 1, 0});
    pulse(2, 4'd1, c0 + 12);
    idle(3);

    chk("a_pending", q_a.size(), 0);
    chk("b_pending", q_b.size(), 0);
    chk("c_pending", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/join_barrier.md
Name: join_barrier

Overview:
- Hardware counterpart of a SystemVerilog fork/join: the join (collector) end of a task-dispatch protocol.
- On `start` it launches N_TASKS parallel workers with a one-cycle `task_start` pulse.
- It collects their `task_done` pulses and issues `release` per the latched mode: JOIN_ALL, JOIN_ANY or JOIN_NONE.
- It sits between a sequencer/controller and a bank of worker engines, and reports completion order and cycle counts.

Parameters:
- N_TASKS, 2, number of parallel workers (1..32).
- CNT_W, 16, width of the elapsed-cycle counter (saturating).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- mode  input  2  join mode, sampled with start (0 JOIN_ALL, 1 JOIN_ANY, 2 JOIN_NONE, 3 treated as JOIN_ALL).
- task_done  input  N_TASKS  per-worker one-cycle completion pulses.
- task_start  output  N_TASKS  all ones for exactly one cycle (LAUNCH).
- busy  output  1  high in every state except IDLE.
- release  output  1  one-cycle pulse: the parent may continue.
- all_retired  output  1  one-cycle pulse: every worker has completed.
- done_mask  output  N_TASKS  accumulated completions of the current fork.
- first_id  output  $clog2(N_TASKS) (min 1)  lowest index among the workers whose done pulses arrived first; held until the next start.
- release_cycles  output  CNT_W  elapsed-counter value when the release condition was detected; held until the next start.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all outputs 0. Reset mid-operation aborts silently, with no release or all_retired pulse.
- States: IDLE, LAUNCH, WAIT, DRAIN. All outputs are registered.
- IDLE:
  - start=1 latches mode, clears done_mask, first_id and release_cycles, and zeroes the counter.
  - Next state is LAUNCH.
- LAUNCH (exactly 1 cycle):
  - task_start=all ones; counter=0 in this cycle; task_done ignored this cycle.
  - JOIN_NONE: release=1 in this same cycle, release_cycles=0, next state DRAIN.
  - Other modes: next state WAIT.
- Counter: increments every cycle after LAUNCH while busy; saturates at 2^CNT_W-1, no wrap.
- WAIT:
  - mask_next = done_mask | task_done.
  - JOIN_ALL, mask_next all ones: next cycle release=1 and all_retired=1; release_cycles = counter in the detect cycle; go IDLE.
  - JOIN_ANY, done_mask==0 and task_done!=0: first_id = lowest set bit of task_done; next cycle release=1; release_cycles latched.
    - If mask_next is also all ones, all_retired=1 in the same cycle as release and go IDLE; otherwise go DRAIN.
- DRAIN:
  - Accumulate done pulses; when mask_next is all ones, all_retired=1 next cycle and go IDLE.
  - first_id is also captured in DRAIN for JOIN_NONE (first done after launch).
- Latency: release and all_retired assert exactly 1 cycle after the qualifying task_done edge; the JOIN_NONE release asserts in LAUNCH.
- Simultaneous done pulses: all are accepted in the same cycle; first_id picks the lowest index.
- Duplicate done for a bit already set: ignored.
- task_done in IDLE: ignored.
- start while busy: ignored; no queueing.
- N_TASKS=1: JOIN_ANY behaves like JOIN_ALL.
- busy drops in the cycle all_retired asserts; a new start is accepted that same cycle (back-to-back forks).

Decomposition:
- join_pkg: join_mode_e (JOIN_ALL, JOIN_ANY, JOIN_NONE), join_state_e (IDLE, LAUNCH, WAIT, DRAIN), and a function all_done(mask).
- One sub-module, join_prio_enc: parameterised lowest-set-bit encoder producing first_id from task_done.
- Counter and FSM stay in join_barrier.

Test Plan:
- JOIN_ALL, N=2; done[0] 20 cycles after LAUNCH, done[1] at 30. Required: release and all_retired together 1 cycle after done[1]; release_cycles=30; done_mask=2'b11; first_id=0.
- JOIN_ANY, same stimulus. Required: release 1 cycle after done[0] with release_cycles=20 and first_id=0; busy stays high; all_retired 1 cycle after done[1].
- JOIN_NONE, same stimulus. Required: release in the LAUNCH cycle together with task_start=2'b11 and release_cycles=0; all_retired 1 cycle after done[1]; no second release.
- JOIN_ANY, N=4; done=4'b1100 on one cycle. Required: first_id=2. Then done[2] again (duplicate) plus done[0], then done[1]. Required: no extra release; all_retired after done[1]; done_mask=4'hF.
- Edge/ignore cases:
  - start asserted during WAIT: ignored, no second task_start.
  - task_done in IDLE: done_mask stays 0.
  - start held high: new LAUNCH in the cycle after all_retired.
- Reset mid-operation:
  - rst_n low during WAIT, after done[0]: all outputs 0 immediately; no release or all_retired after deassert.
  - Next start: clean fork with counter=0.
